// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Data-memory slave for the multi-cycle CPU. Accepts one load/store request,
// waits WAIT_CYCLES wait states, performs the RAM access in a single ACCESS
// cycle, then holds the response until the CPU takes it. Misaligned or
// out-of-range addresses are flagged with resp_err and never touch the RAM.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds valid (and its payload) until that edge;
// ready may depend on state only, never on valid.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_addr, req_wdata   byte address and store data
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  load data (0 for stores/errors), error flag
//   dbg_state             current FSM state (0 IDLE,1 WAIT,2 ACCESS,3 RESP)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] ram [DEPTH];
  logic [AW-1:0] idx;
  logic        addr_err;
  logic        ram_we;

  assign idx      = addr_q[AW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
  // state_q is cleared asynchronously, so a reset before the ACCESS edge
  // removes the write enable and the store never lands.
  assign ram_we   = (state_q == S_ACCESS) && we_q && !addr_err;

  // RAM is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= wdata_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        // Load returns the pre-edge RAM word; stores and errors return 0.
        rdata_d = (!we_q && !addr_err) ? ram[idx] : 32'd0;
        err_d   = addr_err;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    dbg_state  = state_q;
  end

endmodule
